// File: rtl/tour_cmd_seq.sv
// rtl/tour_cmd_seq.sv - knight's tour replay into robot segment commands
// Each one-hot move becomes a vertical then a horizontal command; UART passes through in IDLE.
module tour_cmd_seq #(
  parameter int NUM_MOVES = 24,
  parameter int IDX_W     = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tour_go,
  input  logic [7:0]       move,
  output logic [IDX_W-1:0] mv_indx,
  input  logic [15:0]      cmd_UART,
  input  logic             cmd_rdy_UART,
  output logic             clr_cmd_rdy_UART,
  output logic [15:0]      cmd,
  output logic             cmd_rdy,
  input  logic             clr_cmd_rdy,
  input  logic             send_resp,
  output logic             tour_busy,
  output logic             tour_done,
  output logic             mv_err
);

  typedef enum logic [2:0] {IDLE, VERT, HOLD_V, HORZ, HOLD_H} state_t;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_MOVES - 1);

  state_t           state_q;
  logic [IDX_W-1:0] mv_indx_q;
  logic             tour_done_q;
  logic             mv_err_q;

  logic        move_ok;
  logic        dy_pos, dy_two, dx_pos, dx_two;
  logic [15:0] vert_cmd, horz_cmd;

  // Move bit groups: which encodings go up/right and which span two squares.
  assign move_ok  = (move != 8'h00) && ((move & (move - 8'd1)) == 8'h00);
  assign dy_pos   = |(move & 8'b1000_0111);
  assign dy_two   = |(move & 8'b0011_0011);
  assign dx_pos   = |(move & 8'b1110_0010);
  assign dx_two   = |(move & 8'b1100_1100);
  assign vert_cmd = {4'h2, (dy_pos ? 8'h00 : 8'h7F), (dy_two ? 4'd2 : 4'd1)};
  assign horz_cmd = {4'h3, (dx_pos ? 8'hBF : 8'h3F), (dx_two ? 4'd2 : 4'd1)};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      mv_indx_q   <= '0;
      tour_done_q <= 1'b0;
      mv_err_q    <= 1'b0;
    end else begin
      tour_done_q <= 1'b0;
      mv_err_q    <= 1'b0;
      case (state_q)
        IDLE: begin
          if (tour_go) begin
            mv_indx_q <= '0;
            state_q   <= VERT;
          end
        end
        VERT: begin
          if (!move_ok) begin
            mv_err_q  <= 1'b1;
            mv_indx_q <= '0;
            state_q   <= IDLE;
          end else if (clr_cmd_rdy) begin
            state_q <= HOLD_V;
          end
        end
        HOLD_V: begin
          if (send_resp) state_q <= HORZ;
        end
        HORZ: begin
          if (clr_cmd_rdy) state_q <= HOLD_H;
        end
        HOLD_H: begin
          if (send_resp) begin
            if (mv_indx_q == LAST_IDX) begin
              tour_done_q <= 1'b1;
              mv_indx_q   <= '0;
              state_q     <= IDLE;
            end else begin
              mv_indx_q <= mv_indx_q + 1'b1;
              state_q   <= VERT;
            end
          end
        end
        default: begin
          mv_indx_q <= '0;
          state_q   <= IDLE;
        end
      endcase
    end
  end

  // An illegal move never shows cmd_rdy, so the processor cannot latch it.
  always_comb begin
    cmd              = cmd_UART;
    cmd_rdy          = cmd_rdy_UART;
    clr_cmd_rdy_UART = clr_cmd_rdy;
    case (state_q)
      IDLE: ;
      VERT: begin
        cmd              = vert_cmd;
        cmd_rdy          = move_ok;
        clr_cmd_rdy_UART = 1'b0;
      end
      HOLD_V: begin
        cmd              = vert_cmd;
        cmd_rdy          = 1'b0;
        clr_cmd_rdy_UART = 1'b0;
      end
      HORZ: begin
        cmd              = horz_cmd;
        cmd_rdy          = 1'b1;
        clr_cmd_rdy_UART = 1'b0;
      end
      default: begin
        cmd              = horz_cmd;
        cmd_rdy          = 1'b0;
        clr_cmd_rdy_UART = 1'b0;
      end
    endcase
  end

  assign mv_indx   = mv_indx_q;
  assign tour_busy = (state_q != IDLE);
  assign tour_done = tour_done_q;
  assign mv_err    = mv_err_q;

endmodule

// File: tb/tb_tour_cmd_seq.sv
// tb/tb_tour_cmd_seq.sv - directed vector bench for tour_cmd_seq
module tb_tour_cmd_seq;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        tour_go = 1'b0;
  logic [7:0]  move;
  logic [4:0]  mv_indx;
  logic [15:0] cmd_UART = 16'h0000;
  logic        cmd_rdy_UART = 1'b0;
  logic        clr_cmd_rdy_UART;
  logic [15:0] cmd;
  logic        cmd_rdy;
  logic        clr_cmd_rdy = 1'b0;
  logic        send_resp = 1'b0;
  logic        tour_busy, tour_done, mv_err;

  logic [7:0] move_tab [32];
  assign move = move_tab[mv_indx];

  tour_cmd_seq #(.NUM_MOVES(24), .IDX_W(5)) dut (
    .clk(clk), .rst(rst), .tour_go(tour_go), .move(move), .mv_indx(mv_indx),
    .cmd_UART(cmd_UART), .cmd_rdy_UART(cmd_rdy_UART), .clr_cmd_rdy_UART(clr_cmd_rdy_UART),
    .cmd(cmd), .cmd_rdy(cmd_rdy), .clr_cmd_rdy(clr_cmd_rdy), .send_resp(send_resp),
    .tour_busy(tour_busy), .tour_done(tour_done), .mv_err(mv_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  mv;
    logic [15:0] ev;
    logic [15:0] eh;
  } vec_t;
  vec_t vecs [8];

  int errors = 0;
  int checks = 0;
  int done_pulses = 0;
  int err_pulses = 0;

  always @(negedge clk) begin
    if (tour_done) done_pulses++;
    if (mv_err) err_pulses++;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic do_reset();
    cyc();
    rst = 1'b1;
    #1;
    rst = 1'b0;
  endtask

  task automatic fill(input logic [7:0] m);
    for (int i = 0; i < 32; i++) move_tab[i] = m;
  endtask

  task automatic start_tour();
    cyc(); tour_go = 1'b1;
    cyc(); tour_go = 1'b0;
  endtask

  task automatic accept();
    clr_cmd_rdy = 1'b1; cyc(); clr_cmd_rdy = 1'b0;
  endtask

  task automatic respond();
    send_resp = 1'b1; cyc(); send_resp = 1'b0;
  endtask

  initial begin
    vecs[0] = '{8'h01, 16'h2002, 16'h33F1};
    vecs[1] = '{8'h02, 16'h2002, 16'h3BF1};
    vecs[2] = '{8'h04, 16'h2001, 16'h33F2};
    vecs[3] = '{8'h08, 16'h27F1, 16'h33F2};
    vecs[4] = '{8'h10, 16'h27F2, 16'h33F1};
    vecs[5] = '{8'h20, 16'h27F2, 16'h3BF1};
    vecs[6] = '{8'h40, 16'h27F1, 16'h3BF2};
    vecs[7] = '{8'h80, 16'h2001, 16'h3BF2};
    fill(8'h02);

    #2;
    chk("rst_mv_indx", 32'(mv_indx), 0);
    chk("rst_busy", 32'(tour_busy), 0);
    chk("rst_done", 32'(tour_done), 0);
    chk("rst_err", 32'(mv_err), 0);
    cyc(); rst = 1'b0;

    // UART pass-through
    cyc();
    cmd_UART = 16'h2004; cmd_rdy_UART = 1'b1; clr_cmd_rdy = 1'b1;
    #1;
    chk("pt_cmd", 32'(cmd), 32'h2004);
    chk("pt_cmd_rdy", 32'(cmd_rdy), 1);
    chk("pt_clr_uart", 32'(clr_cmd_rdy_UART), 1);
    chk("pt_busy", 32'(tour_busy), 0);
    cyc(); clr_cmd_rdy = 1'b0; cmd_rdy_UART = 1'b0;

    // one move per encoding
    for (int v = 0; v < 8; v++) begin
      do_reset();
      fill(vecs[v].mv);
      start_tour();
      chk($sformatf("v%0d_rdy_v", v), 32'(cmd_rdy), 1);
      chk($sformatf("v%0d_cmd_v", v), 32'(cmd), 32'(vecs[v].ev));
      accept();
      chk($sformatf("v%0d_holdv_rdy", v), 32'(cmd_rdy), 0);
      respond();
      chk($sformatf("v%0d_rdy_h", v), 32'(cmd_rdy), 1);
      chk($sformatf("v%0d_cmd_h", v), 32'(cmd), 32'(vecs[v].eh));
      accept();
      respond();
      chk($sformatf("v%0d_idx", v), 32'(mv_indx), 1);
    end

    // full tour cycling all encodings
    do_reset();
    for (int i = 0; i < 32; i++) move_tab[i] = vecs[i % 8].mv;
    done_pulses = 0;
    start_tour();
    for (int n = 0; n < 48; n++) begin
      int w;
      w = 0;
      while (!cmd_rdy && w < 10) begin cyc(); w++; end
      chk("tour_rdy", 32'(cmd_rdy), 1);
      chk("tour_idx", 32'(mv_indx), 32'(n / 2));
      chk("tour_cmd", 32'(cmd), (n % 2 == 0) ? 32'(vecs[(n / 2) % 8].ev) : 32'(vecs[(n / 2) % 8].eh));
      accept();
      respond();
    end
    chk("tour_done_pulse", 32'(tour_done), 1);
    chk("tour_end_busy", 32'(tour_busy), 0);
    chk("tour_end_idx", 32'(mv_indx), 0);
    cyc();
    chk("tour_done_count", 32'(done_pulses), 1);
    cmd_UART = 16'h1234; cmd_rdy_UART = 1'b1;
    #1;
    chk("tour_pt_cmd", 32'(cmd), 32'h1234);
    chk("tour_pt_rdy", 32'(cmd_rdy), 1);
    cyc(); cmd_rdy_UART = 1'b0;

    // ignored events and mid-tour reset
    do_reset();
    fill(8'h02);
    done_pulses = 0;
    start_tour();
    send_resp = 1'b1; cyc(); send_resp = 1'b0;
    chk("early_resp_rdy", 32'(cmd_rdy), 1);
    chk("early_resp_cmd", 32'(cmd), 32'h2002);
    tour_go = 1'b1; cyc(); tour_go = 1'b0;
    chk("go_busy_idx", 32'(mv_indx), 0);
    chk("go_busy_rdy", 32'(cmd_rdy), 1);
    cmd_rdy_UART = 1'b1; clr_cmd_rdy = 1'b1; send_resp = 1'b1;
    #1;
    chk("uart_blocked", 32'(clr_cmd_rdy_UART), 0);
    cyc(); clr_cmd_rdy = 1'b0; send_resp = 1'b0; cmd_rdy_UART = 1'b0;
    chk("same_cycle_holdv", 32'(cmd_rdy), 0);
    chk("same_cycle_cmd", 32'(cmd), 32'h2002);
    accept();
    chk("clr_in_holdv", 32'(cmd_rdy), 0);
    respond();
    chk("horz_after", 32'(cmd), 32'h3BF1);
    accept();
    chk("in_hold_h", 32'(tour_busy), 1);
    rst = 1'b1;
    #1;
    chk("midrst_busy", 32'(tour_busy), 0);
    chk("midrst_idx", 32'(mv_indx), 0);
    rst = 1'b0;
    cyc(); cyc();
    chk("midrst_no_done", 32'(done_pulses), 0);

    // illegal move at index 5
    do_reset();
    fill(8'h02);
    move_tab[5] = 8'h00;
    err_pulses = 0;
    start_tour();
    for (int m = 0; m < 5; m++) begin
      accept(); respond(); accept(); respond();
    end
    chk("err_at_idx", 32'(mv_indx), 5);
    chk("err_no_rdy", 32'(cmd_rdy), 0);
    cyc();
    chk("err_pulse", 32'(mv_err), 1);
    chk("err_idle", 32'(tour_busy), 0);
    chk("err_idx0", 32'(mv_indx), 0);
    cyc();
    chk("err_one_pulse", 32'(err_pulses), 1);

    // a non-one-hot encoding is also rejected
    do_reset();
    fill(8'h03);
    start_tour();
    chk("multi_hot_no_rdy", 32'(cmd_rdy), 0);
    cyc();
    chk("multi_hot_err", 32'(mv_err), 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end
endmodule

// File: doc/tour_cmd_seq.md
Name: tour_cmd_seq

Overview:
- Replays a solved knight's tour as robot movement commands once the tour solver asserts done.
- Steps the solver's replay index through all moves and reads each one-hot move.
- Splits each move into a vertical segment command, then a horizontal segment command, handshaking each with the command processor.
- When no tour is running, passes UART commands straight through to the command processor.

Parameters:
- NUM_MOVES, 24, number of moves in a tour (replayed at indices 0..NUM_MOVES-1).
- IDX_W, 5, width of replay index.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- tour_go  in  1  start replay; sampled only in IDLE
- move  in  8  one-hot move from solver at index mv_indx (combinational, valid same cycle)
- mv_indx  out  IDX_W  replay index to solver
- cmd_UART  in  16  command from UART wrapper
- cmd_rdy_UART  in  1  UART command valid
- clr_cmd_rdy_UART  out  1  UART command consumed
- cmd  out  16  command to command processor
- cmd_rdy  out  1  cmd valid
- clr_cmd_rdy  in  1  command processor accepted cmd
- send_resp  in  1  command processor finished current command (1-cycle pulse)
- tour_busy  out  1  high in every state except IDLE
- tour_done  out  1  1-cycle pulse after final segment completes
- mv_err  out  1  1-cycle pulse on illegal move encoding

Behaviour:
- Reset values: state IDLE, mv_indx 0, tour_done 0, mv_err 0, tour_busy 0. cmd_rdy, cmd and clr_cmd_rdy_UART follow the IDLE pass-through.
- Move table, as bit: dx,dy.
  - [0]: -1,+2
  - [1]: +1,+2
  - [2]: -2,+1
  - [3]: -2,-1
  - [4]: -1,-2
  - [5]: +1,-2
  - [6]: +2,-1
  - [7]: +2,+1
- cmd format: [15:12] opcode, [11:4] heading, [3:0] square count.
  - Vertical segment: opcode 4'h2. Heading 8'h00 if dy>0, else 8'h7F. Count |dy|.
  - Horizontal segment: opcode 4'h3 (move with fanfare). Heading 8'hBF if dx>0, else 8'h3F. Count |dx|.
- States: IDLE, VERT, HOLD_V, HORZ, HOLD_H. Outputs are Moore from state, except cmd, which is combinational from state and move.
- IDLE
  - Pass-through: cmd=cmd_UART, cmd_rdy=cmd_rdy_UART, clr_cmd_rdy_UART=clr_cmd_rdy.
  - tour_go=1 → mv_indx<=0, next state VERT. The first tour cmd_rdy is visible 1 cycle after tour_go.
- VERT
  - Drives the vertical cmd with cmd_rdy=1 and clr_cmd_rdy_UART=0. cmd_rdy_UART is ignored.
  - clr_cmd_rdy=1 → HOLD_V.
- HOLD_V
  - cmd_rdy=0, cmd held.
  - send_resp=1 → HORZ.
- HORZ
  - Drives the horizontal cmd with cmd_rdy=1.
  - clr_cmd_rdy=1 → HOLD_H.
- HOLD_H
  - send_resp=1 and mv_indx==NUM_MOVES-1 → IDLE, tour_done pulses for 1 cycle, mv_indx<=0.
  - send_resp=1 otherwise → mv_indx<=mv_indx+1, next state VERT.
- Illegal move: check in VERT. If move==0 or move is not one-hot, the block stays out of HOLD_V, goes to IDLE, pulses mv_err, sets mv_indx<=0, and never asserts cmd_rdy for that move.
- send_resp in VERT or HORZ (before acceptance) is ignored.
- clr_cmd_rdy in HOLD_V or HOLD_H is ignored.
- clr_cmd_rdy and send_resp in the same cycle in VERT/HORZ: only the acceptance is taken; the block advances one state.
- tour_go outside IDLE is ignored.
- rst asserted mid-tour: immediately IDLE, mv_indx=0, no tour_done.
- mv_indx is never driven ≥ NUM_MOVES.

Test Plan:
- Pass-through: in IDLE, drive cmd_UART=16'h2004 with cmd_rdy_UART=1 and pulse clr_cmd_rdy → cmd=16'h2004, cmd_rdy=1, clr_cmd_rdy_UART pulses same cycle, tour_busy=0.
- Single move: tour_go with move=8'h02 →
  - cmd_rdy=1 next cycle, cmd=16'h2002.
  - After clr_cmd_rdy then send_resp: cmd=16'h3BF1.
  - After clr_cmd_rdy then send_resp: mv_indx=1.
- Full tour: move model cycles through all 8 encodings, immediate handshakes → exactly 48 accepted commands, mv_indx 0..23, one tour_done pulse, then back to UART pass-through.
- Move 8'h08 → cmd=16'h27F1 then 16'h33F2. Move 8'h40 → 16'h27F1 then 16'h3BF2.
- Early send_resp before clr_cmd_rdy in VERT → ignored, cmd_rdy stays 1. tour_go while busy → no restart. cmd_rdy_UART high during tour → clr_cmd_rdy_UART stays 0.
- Error and reset:
  - move=8'h00 at mv_indx=5 → mv_err pulse, IDLE, mv_indx=0.
  - rst pulsed in HOLD_H → tour_busy=0 and mv_indx=0 immediately, no tour_done.
